// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite in row-major order, fetches each
// pixel colour from an external synchronous ROM and emits one plot command per
// pixel. Off-screen and transparent pixels still take their slot, so the
// schedule from start to done is always N+3 cycles.
module sprite_blitter #(
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned C_W       = 3,
    parameter int unsigned SPR_W     = 5,
    parameter int unsigned SPR_H     = 6,
    parameter int unsigned ORG_X     = 3,
    parameter int unsigned ORG_Y     = 3,
    parameter int unsigned X_MAX     = 159,
    parameter int unsigned Y_MAX     = 119,
    parameter bit          TRANSP_EN = 1'b1,
    parameter logic [C_W-1:0] TRANSP_C = '0,
    parameter int unsigned A_W       = $clog2(SPR_W * SPR_H)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           erase,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [C_W-1:0] bg_color,
    output logic [A_W-1:0] rom_addr,
    input  logic [C_W-1:0] rom_data,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic [C_W-1:0] color,
    output logic           en,
    output logic           busy,
    output logic           done
);

    localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [COL_W-1:0] LP_COL_LAST = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0] LP_ROW_LAST = ROW_W'(SPR_H - 1);
    localparam logic [X_W-1:0]   LP_X_MAX    = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   LP_Y_MAX    = Y_W'(Y_MAX);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_t;

    state_t         r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [A_W-1:0] r_addr;
    logic           r_drain;
    logic           r_busy;
    logic           r_done;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_erase;
    logic [C_W-1:0] r_bg;

    // Fetch stage: tags the pixel whose ROM data arrives this cycle
    logic             r_s1_valid;
    logic [COL_W-1:0] r_s1_col;
    logic [ROW_W-1:0] r_s1_row;

    logic [X_W-1:0] r_out_x;
    logic [Y_W-1:0] r_out_y;
    logic [C_W-1:0] r_color;
    logic           r_en;

    logic [X_W:0]   w_px;
    logic [Y_W:0]   w_py;
    logic           w_in_x;
    logic           w_in_y;
    logic           w_opaque;
    logic           w_en;
    logic [C_W-1:0] w_color;

    // Signed screen position: the extra top bit flags negative or overflowed results
    assign w_px     = (X_W+1)'(r_x) - (X_W+1)'(ORG_X) + (X_W+1)'(r_s1_col);
    assign w_py     = (Y_W+1)'(r_y) - (Y_W+1)'(ORG_Y) + (Y_W+1)'(r_s1_row);
    assign w_in_x   = !w_px[X_W] && (w_px[X_W-1:0] <= LP_X_MAX);
    assign w_in_y   = !w_py[Y_W] && (w_py[Y_W-1:0] <= LP_Y_MAX);
    // Transparency looks at ROM data even when erasing, so erase hits only the opaque footprint
    assign w_opaque = !(TRANSP_EN && (rom_data == TRANSP_C));
    assign w_en     = r_s1_valid && w_in_x && w_in_y && w_opaque;
    assign w_color  = r_erase ? r_bg : rom_data;

    // Control FSM: accepts requests, walks the sprite addresses, drains, pulses done
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_erase <= 1'b0;
            r_bg    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_erase <= erase;
                        r_bg    <= bg_color;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StScan;
                    end
                end
                StScan: begin
                    if ((r_col == LP_COL_LAST) && (r_row == LP_ROW_LAST)) begin
                        r_drain <= 1'b0;
                        r_state <= StDrain;
                    end else begin
                        r_addr <= r_addr + A_W'(1);
                        if (r_col == LP_COL_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (r_drain) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Pixel pipeline: tag fetched pixels, then clip, key out transparency and register the plot
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_out_x    <= '0;
            r_out_y    <= '0;
            r_color    <= '0;
            r_en       <= 1'b0;
        end else begin
            r_s1_valid <= (r_state == StScan);
            r_s1_col   <= r_col;
            r_s1_row   <= r_row;
            r_en       <= w_en;
            if (w_en) begin
                r_out_x <= w_px[X_W-1:0];
                r_out_y <= w_py[Y_W-1:0];
                r_color <= w_color;
            end
        end
    end

    assign rom_addr = r_addr;
    assign out_x    = r_out_x;
    assign out_y    = r_out_y;
    assign color    = r_color;
    assign en       = r_en;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a behavioural ROM feeds the DUT, expected plots are
// queued at start time and checked (position, colour, cycle) as en strobes appear.
module tb_sprite_blitter;

    localparam int N = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       erase;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] bg_color;
    logic [4:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] color;
    logic       en;
    logic       busy;
    logic       done;

    sprite_blitter dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .erase    (erase),
        .x        (x),
        .y        (y),
        .bg_color (bg_color),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_x    (out_x),
        .out_y    (out_y),
        .color    (color),
        .en       (en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [2:0] rom [0:31];
    always @(posedge clock) rom_data <= rom[rom_addr];

    typedef struct {
        int px;
        int py;
        int c;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: one entry per plotted pixel, pixel k shows up in cycle t+3+k
    task automatic push_exp(input int sx, input int sy, input logic ser,
                            input int sbg, input int t, input int kmax);
        for (int k = 0; k < N && k < kmax; k++) begin
            int col = k % 5;
            int row = k / 5;
            int px = sx - 3 + col;
            int py = sy - 3 + row;
            int rc = int'(rom[k]);
            exp_t ne;
            if (px >= 0 && px <= 159 && py >= 0 && py <= 119 && rc != 0) begin
                ne.px  = px;
                ne.py  = py;
                ne.c   = ser ? sbg : rc;
                ne.cyc = t + 3 + k;
                q.push_back(ne);
            end
        end
    endtask

    // Scoreboard consumer, sampled on the falling edge
    always @(negedge clock) begin
        if (en === 1'b1) begin
            if (q.size() == 0) begin
                check_eq("extra_en", cyc, -1);
            end else begin
                e = q.pop_front();
                check_eq("plot_cyc", cyc, e.cyc);
                check_eq("plot_x", int'(out_x), e.px);
                check_eq("plot_y", int'(out_y), e.py);
                check_eq("plot_c", int'(color), e.c);
            end
        end
        if (done === 1'b1) n_done++;
    end

    task automatic start_sprite(input int sx, input int sy, input logic ser,
                                input int sbg, input int kmax, output int t);
        @(posedge clock);
        #1;
        x        = 8'(sx);
        y        = 7'(sy);
        erase    = ser;
        bg_color = 3'(sbg);
        start    = 1'b1;
        t        = cyc;
        push_exp(sx, sy, ser, sbg, t, kmax);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int t, input string tag);
        int seen = -1;
        int d0 = n_done;
        for (int i = 0; i < N + 8 && seen < 0; i++) begin
            @(negedge clock);
            if (cyc == t + 1)     check_eq({tag, "_busy_first"}, int'(busy), 1);
            if (cyc == t + N + 2) check_eq({tag, "_busy_last"}, int'(busy), 1);
            if (cyc == t + N + 3) check_eq({tag, "_busy_off"}, int'(busy), 0);
            if (done === 1'b1) seen = cyc;
        end
        check_eq({tag, "_done_cyc"}, seen, t + N + 3);
        check_eq({tag, "_leftover"}, q.size(), 0);
        @(negedge clock);
        check_eq({tag, "_done_pulse"}, n_done - d0, 1);
    endtask

    initial begin
        int t;
        int d0;
        reset    = 1'b1;
        start    = 1'b0;
        erase    = 1'b0;
        x        = '0;
        y        = '0;
        bg_color = '0;
        for (int i = 0; i < 32; i++) rom[i] = 3'b100;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_out_x", int'(out_x), 0);
        check_eq("rst_out_y", int'(out_y), 0);
        check_eq("rst_color", int'(color), 0);
        check_eq("rst_addr", int'(rom_addr), 0);
        check_eq("rst_en", int'(en), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        reset = 1'b0;

        // Full opaque sprite centred on (80,60)
        start_sprite(80, 60, 1'b0, 0, N, t);
        wait_done(t, "full");

        // Transparent top-left pixel
        rom[0] = 3'b000;
        start_sprite(80, 60, 1'b0, 0, N, t);
        wait_done(t, "transp");

        // Erase paints bg over the opaque footprint only
        start_sprite(80, 60, 1'b1, 1, N, t);
        wait_done(t, "erase");

        // Top-left clipping, no wrap to high coordinates
        for (int i = 0; i < 32; i++) rom[i] = 3'b100;
        start_sprite(1, 0, 1'b0, 0, N, t);
        wait_done(t, "clip_tl");

        // Bottom-right clipping with mixed colours and random transparency
        for (int i = 0; i < 32; i++) rom[i] = 3'($urandom_range(0, 7));
        start_sprite(159, 119, 1'b0, 0, N, t);
        wait_done(t, "clip_br");

        // Start pulse mid-sprite must be ignored
        for (int i = 0; i < 32; i++) rom[i] = 3'b110;
        start_sprite(40, 30, 1'b0, 0, N, t);
        while (cyc < t + 10) begin
            @(posedge clock);
            #1;
        end
        x     = 8'd20;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        x     = 8'd40;
        wait_done(t, "restart_ign");

        // Reset mid-sprite: pixels 0..9 already plotted, then silence
        d0 = n_done;
        start_sprite(80, 60, 1'b0, 0, 10, t);
        while (cyc < t + 12) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("abort_en", int'(en), 0);
        check_eq("abort_busy", int'(busy), 0);
        repeat (40) @(negedge clock);
        check_eq("abort_no_done", n_done - d0, 0);
        check_eq("abort_leftover", q.size(), 0);

        // Fresh sprite after the abort runs the full schedule
        start_sprite(100, 50, 1'b0, 0, N, t);
        wait_done(t, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
